// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB register-file slave.
// Optional byte-strobe support is controlled by the APB_REGFILE_PSTRB_EN macro.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int WCOUNT_W        = 16;
    localparam int ADDR_ALIGN_BITS = 2;
    localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/apb_regfile_if.sv
// APB bus bundle between master and register-file slave.
// pstrb_i exists only when APB_REGFILE_PSTRB_EN is defined.
interface apb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              psel_i;
    logic              penable_i;
    logic [ADDR_W-1:0] paddr_i;
    logic              pwrite_i;
    logic [DATA_W-1:0] pwdata_i;
`ifdef APB_REGFILE_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb_i;
`endif
    logic [DATA_W-1:0] prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
`ifdef APB_REGFILE_PSTRB_EN
        output pstrb_i,
`endif
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
`ifdef APB_REGFILE_PSTRB_EN
        input  pstrb_i,
`endif
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_regfile_slave_wait_ctrl.sv
// APB phase FSM and wait-state counter; produces the completion strobe
// and flags transfers that began with penable already high.
module apb_wait_ctrl
    import apb_regfile_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic psel,
    input  logic penable,
    output logic complete,
    output logic proto_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e              state_q;
    apb_state_e              state_cur;
    apb_state_e              state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic                    perr_q;
    logic                    idle_perr;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_cur != ACCESS && state_d == ACCESS)
                cnt_q <= '0;
            else if (state_cur == ACCESS && cnt_q < WAIT_MAX)
                cnt_q <= cnt_q + 1'b1;
            if (idle_perr)
                perr_q <= 1'b1;
            else if (state_d != ACCESS)
                perr_q <= 1'b0;
        end
    end

    // The setup phase is recognised in the cycle the master drives it, so a
    // zero-wait transfer completes on the very next (access) cycle.
    always_comb begin
        state_cur = state_q;
        if (state_q == IDLE && psel && !penable)
            state_cur = SETUP;
        idle_perr = (state_cur == IDLE) && psel && penable;
        state_d   = state_cur;
        unique case (state_cur)
            IDLE:    state_d = idle_perr ? ACCESS : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (!psel || complete) ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        complete  = (state_q == ACCESS) && psel && penable && (cnt_q == WAIT_MAX);
        proto_err = perr_q;
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: NUM_REGS read/write words plus a read-only write
// counter (WCOUNT). Define APB_REGFILE_PSTRB_EN for byte-lane write strobes.
module apb_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'hA000,
    parameter int                WAIT_STATES = 0
) (
    input  logic         pclk,
    input  logic         preset_n,
    apb_regfile_if.slave bus
);

    logic                complete;
    logic                proto_err;
    logic [ADDR_W-1:0]   word_idx;
    logic                aligned;
    logic                addr_ok;
    logic                is_wcount;
    logic                err;
    logic                wr_ok;
    logic                reg_we;
    logic                wc_clr;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [WCOUNT_W-1:0] wcount_q;

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .psel      (bus.psel_i),
        .penable   (bus.penable_i),
        .complete  (complete),
        .proto_err (proto_err)
    );

    // Addresses below BASE_ADDR wrap to huge indices and fall out of range.
    always_comb begin
        word_idx  = (bus.paddr_i - BASE_ADDR) >> ADDR_ALIGN_BITS;
        aligned   = (bus.paddr_i[ADDR_ALIGN_BITS-1:0] == '0);
        addr_ok   = aligned && (word_idx <= ADDR_W'(NUM_REGS));
        is_wcount = (word_idx == ADDR_W'(NUM_REGS));
        err       = !addr_ok || proto_err;
        wr_ok     = complete && bus.pwrite_i && !err;
        reg_we    = wr_ok && !is_wcount;
        wc_clr    = wr_ok && is_wcount;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (reg_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (word_idx == ADDR_W'(i)) begin
`ifdef APB_REGFILE_PSTRB_EN
                    for (int b = 0; b < DATA_W/8; b++)
                        if (bus.pstrb_i[b])
                            regs[i][8*b +: 8] <= bus.pwdata_i[8*b +: 8];
`else
                    regs[i] <= bus.pwdata_i;
`endif
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)
            wcount_q <= '0;
        else if (wc_clr)
            wcount_q <= '0;
        else if (reg_we && wcount_q != '1)
            wcount_q <= wcount_q + 1'b1;
    end

    always_comb begin
        rd_data = '0;
        if (complete && !bus.pwrite_i && !err) begin
            if (is_wcount)
                rd_data = DATA_W'(wcount_q);
            else
                for (int i = 0; i < NUM_REGS; i++)
                    if (word_idx == ADDR_W'(i))
                        rd_data = regs[i];
        end
    end

    assign bus.prdata_o  = rd_data;
    assign bus.pready_o  = complete;
    assign bus.pslverr_o = complete && err;

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 Parameter DATA_W, default 32: data bus width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32: address bus width.
REQ-003 Parameter NUM_REGS, default 8: number of read/write registers (1..64).
REQ-004 Parameter BASE_ADDR, default 32'hA000: byte address of register 0.
REQ-005 Parameter WAIT_STATES, default 0: access-phase cycles with pready_o low before completion (0..15).
REQ-006 pclk  input  1  single clock; all state on rising edge.
REQ-007 preset_n  input  1  reset, asynchronous assert, active-low.
REQ-008 psel_i  input  1  slave select.
REQ-009 penable_i  input  1  access-phase indicator.
REQ-010 paddr_i  input  ADDR_W  byte address.
REQ-011 pwrite_i  input  1  1 = write, 0 = read.
REQ-012 pwdata_i  input  DATA_W  write data.
REQ-013 prdata_o  output  DATA_W  read data, valid only in the completion cycle.
REQ-014 pready_o  output  1  transfer completion.
REQ-015 pslverr_o  output  1  error response, valid only in the completion cycle.

Function
REQ-016 Address map:
- reg[i] at BASE_ADDR + 4*i, i < NUM_REGS.
- Read-only status register WCOUNT at BASE_ADDR + 4*NUM_REGS.
REQ-017 FSM states IDLE, SETUP, ACCESS.
- IDLE->SETUP on psel_i & ~penable_i.
- SETUP->ACCESS unconditionally.
- ACCESS->SETUP on completion when psel_i & ~penable_i follows; otherwise ACCESS->IDLE on completion.
- ACCESS->IDLE whenever psel_i drops (abort; no register update).
REQ-018 Wait counter:
- Clears on entry to ACCESS.
- Increments each ACCESS cycle while below WAIT_STATES.
- Completion cycle = ACCESS & psel_i & penable_i & counter == WAIT_STATES; pready_o is high only in that cycle (combinational from state).
REQ-019 With WAIT_STATES=0, completion occurs in the first access-phase cycle (classic two-cycle transfer).
REQ-020 Address decode:
- Decoded address = paddr_i - BASE_ADDR; valid if word-aligned (paddr_i[1:0]==0) and index <= NUM_REGS.
- Otherwise invalid.
REQ-021 Write: in the completion cycle with a valid address, index < NUM_REGS and no error, reg[index] SHALL take pwdata_i at the clock edge.
REQ-022 WCOUNT: 16-bit, zero-extended to DATA_W.
- Increments by 1 on every successful register write; saturates at 16'hFFFF.
- Any write to the WCOUNT address clears it to 0 and is not counted.
REQ-023 Read: in the completion cycle, prdata_o = addressed register (or WCOUNT); prdata_o SHALL be 0 in all other cycles and on error.
REQ-024 pslverr_o SHALL be high in the completion cycle if:
- the address is invalid or misaligned, or
- penable_i was observed high while in IDLE (protocol error; slave enters ACCESS directly and completes with error).
REQ-025 An erroring write SHALL NOT modify any register or WCOUNT.
REQ-026 Signals paddr_i, pwrite_i and pwdata_i are sampled at the completion cycle; their changes during wait states are not tracked.

Reset
REQ-027 On preset_n low:
- state=IDLE, wait counter=0.
- All reg[i]=0, WCOUNT=0.
- pready_o=0, pslverr_o=0, prdata_o=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no register update; after release, the slave waits in IDLE for a new setup phase.

Configuration
REQ-029 Macro APB_REGFILE_PSTRB_EN:
- When defined, it adds input pstrb_i (DATA_W/8 bits). A write updates only the byte lanes whose strobe is 1; a write with all strobes 0 is a successful no-op write and still increments WCOUNT.
- When undefined, pstrb_i does not exist and every write updates the full word.

Structure
REQ-030 Package apb_regfile_pkg SHALL hold:
- the state enum typedef (IDLE/SETUP/ACCESS),
- WCOUNT_W=16,
- the address-alignment constant.
REQ-031 Sub-module apb_wait_ctrl SHALL contain the FSM and wait counter, and output the completion strobe; the top level holds decode, register array, WCOUNT and the read mux.

Verification
REQ-032 WAIT_STATES=0: write 32'hDEADBEEF to 32'hA004, then read 32'hA004 -> pready_o high in 2nd cycle of each transfer, prdata_o=32'hDEADBEEF, pslverr_o=0, WCOUNT=1.
REQ-033 WAIT_STATES=3: read 32'hA000 -> pready_o low for 3 access cycles, high on the 4th, prdata_o=0.
REQ-034 Write 32'h1234 to 32'hA002 (misaligned) and to 32'hA000+4*(NUM_REGS+1) -> pslverr_o=1 on completion, all registers and WCOUNT unchanged.
REQ-035 Write to WCOUNT address after 5 writes -> WCOUNT reads 0; 65540 writes -> WCOUNT reads 16'hFFFF.
REQ-036 With APB_REGFILE_PSTRB_EN: reg0=32'hFFFFFFFF, write 32'h00000000 with pstrb_i=4'b0101 -> reg0 reads 32'hFF00FF00.
REQ-037 Assert preset_n low during a wait state -> outputs 0, reg unchanged from pre-transfer reset value 0, the next transfer completes normally.
